// File: rtl/clkdiv_rst_seq.sv
// rtl/clkdiv_rst_seq.sv - reset sequencer for the CLKDIV stage: lock filter, reset hold, settle, ready
module clkdiv_rst_seq #(
    parameter int LOCK_FILTER   = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic       hclkin,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       sw_restart,
    output logic       div_resetn,
    output logic       div_ready,
    output logic [1:0] seq_state,
    output logic [7:0] lost_cnt
);

    // The shared counter must hold the largest terminal value of any phase.
    localparam int MAX_LH = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
    localparam int MAX_P  = (MAX_LH > SETTLE_CYCLES) ? MAX_LH : SETTLE_CYCLES;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] LF_LAST     = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_SETTLE    = 2'd2,
        ST_READY     = 2'd3
    } state_t;

    logic             sync1_q;
    logic             lock_s_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resetn_q, resetn_d;
    logic             ready_q, ready_d;
    logic [7:0]       lost_q, lost_d;

    // Two-flop synchronizer bringing the asynchronous PLL lock into hclkin.
    always_ff @(posedge hclkin or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_lock;
            lock_s_q <= sync1_q;
        end
    end

    // Next-state logic; outputs are computed here so they change on the transition edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        resetn_d = resetn_q;
        ready_d  = ready_q;
        lost_d   = lost_q;

        if (state_q != ST_WAIT_LOCK && !lock_s_q) begin
            // Lock loss outranks a simultaneous restart.
            state_d  = ST_WAIT_LOCK;
            cnt_d    = '0;
            resetn_d = 1'b0;
            ready_d  = 1'b0;
            if (lost_q != 8'hFF) begin
                lost_d = lost_q + 8'd1;
            end
        end else if (state_q != ST_WAIT_LOCK && sw_restart) begin
            // Lock is still good, so skip the filter and go straight back to HOLD.
            state_d  = ST_HOLD;
            cnt_d    = '0;
            resetn_d = 1'b0;
            ready_d  = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    resetn_d = 1'b0;
                    ready_d  = 1'b0;
                    if (!lock_s_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == LF_LAST) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    resetn_d = 1'b0;
                    ready_d  = 1'b0;
                    if (cnt_q == HOLD_LAST) begin
                        state_d  = ST_SETTLE;
                        cnt_d    = '0;
                        resetn_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    resetn_d = 1'b1;
                    ready_d  = 1'b0;
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_READY;
                        cnt_d   = '0;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_READY: begin
                    resetn_d = 1'b1;
                    ready_d  = 1'b1;
                end
            endcase
        end
    end

    // State, counter and output registers; reset pulls div_resetn low asynchronously.
    always_ff @(posedge hclkin or posedge reset) begin
        if (reset) begin
            state_q  <= ST_WAIT_LOCK;
            cnt_q    <= '0;
            resetn_q <= 1'b0;
            ready_q  <= 1'b0;
            lost_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            resetn_q <= resetn_d;
            ready_q  <= ready_d;
            lost_q   <= lost_d;
        end
    end

    assign div_resetn = resetn_q;
    assign div_ready  = ready_q;
    assign seq_state  = state_q;
    assign lost_cnt   = lost_q;

endmodule

// File: tb/tb_clkdiv_rst_seq.sv
// tb/tb_clkdiv_rst_seq.sv - directed self-checking bench for clkdiv_rst_seq
module tb_clkdiv_rst_seq;

    logic       hclkin = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       sw_restart;
    logic       div_resetn;
    logic       div_ready;
    logic [1:0] seq_state;
    logic [7:0] lost_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_lost;

    always #5 hclkin = ~hclkin;

    clkdiv_rst_seq #(
        .LOCK_FILTER  (4),
        .HOLD_CYCLES  (16),
        .SETTLE_CYCLES(8)
    ) dut (
        .hclkin    (hclkin),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .sw_restart(sw_restart),
        .div_resetn(div_resetn),
        .div_ready (div_ready),
        .seq_state (seq_state),
        .lost_cnt  (lost_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge hclkin);
        @(negedge hclkin);
    endtask

    // {seq_state, div_resetn, div_ready} k edges after the first, with HOLD entered at edge h.
    function automatic logic [3:0] seq_exp(input int k, input int h);
        logic [1:0] st;
        logic       rn;
        logic       rd;
        if (k < h)            st = 2'd0;
        else if (k < h + 16)  st = 2'd1;
        else if (k < h + 24)  st = 2'd2;
        else                  st = 2'd3;
        rn = (k >= h + 16);
        rd = (k >= h + 24);
        return {st, rn, rd};
    endfunction

    task automatic run_seq(input string tag, input int h, input int n);
        for (int k = 0; k <= n; k++) begin
            step();
            if (k == 0) sw_restart = 1'b0;
            check(tag, 32'({seq_state, div_resetn, div_ready}), 32'(seq_exp(k, h)));
        end
    endtask

    task automatic lose_lock(input string tag, input int exp_l);
        pll_lock = 1'b0;
        step();
        check({tag, "_f0"}, 32'(seq_state), 32'd3);
        step();
        check({tag, "_f1"}, 32'(seq_state), 32'd3);
        step();
        check({tag, "_f2"}, 32'({seq_state, div_resetn, div_ready}), 32'd0);
        check({tag, "_lost"}, 32'(lost_cnt), 32'(exp_l));
    endtask

    initial begin
        reset      = 1'b1;
        pll_lock   = 1'b0;
        sw_restart = 1'b0;
        repeat (3) @(negedge hclkin);
        check("reset_vals", 32'({seq_state, div_resetn, div_ready, lost_cnt}), 32'd0);
        reset = 1'b0;

        // Power-up with no lock: everything stays at reset values.
        for (int k = 0; k < 100; k++) begin
            step();
            check("powerup", 32'({seq_state, div_resetn, div_ready, lost_cnt}), 32'd0);
        end

        // Lock high 3 samples, low 1, high again: HOLD only after 4 consecutive highs (edge 9).
        pll_lock = 1'b1;
        for (int k = 0; k <= 33; k++) begin
            step();
            if (k == 2) pll_lock = 1'b0;
            if (k == 3) pll_lock = 1'b1;
            check("filter", 32'({seq_state, div_resetn, div_ready}), 32'(seq_exp(k, 9)));
        end
        check("filter_lost", 32'(lost_cnt), 32'd0);

        // Lock loss in READY, restart ignored in WAIT_LOCK, then the full default sequence.
        lose_lock("loss1", 1);
        sw_restart = 1'b1;
        step();
        sw_restart = 1'b0;
        check("restart_wait", 32'(seq_state), 32'd0);
        step();
        check("restart_wait2", 32'({seq_state, div_resetn, div_ready}), 32'd0);
        pll_lock = 1'b1;
        run_seq("normal", 5, 30);
        check("normal_lost", 32'(lost_cnt), 32'd1);

        // Restart from READY.
        sw_restart = 1'b1;
        run_seq("restart_ready", 0, 26);

        // Restart part way through HOLD restarts the hold count.
        sw_restart = 1'b1;
        run_seq("restart_hold_a", 0, 10);
        sw_restart = 1'b1;
        run_seq("restart_hold_b", 0, 26);
        check("restart_lost", 32'(lost_cnt), 32'd1);

        // Restart on the same edge the FSM sees lock_s low is treated as lock loss.
        pll_lock = 1'b0;
        step();
        step();
        sw_restart = 1'b1;
        step();
        sw_restart = 1'b0;
        check("simul_state", 32'({seq_state, div_resetn, div_ready}), 32'd0);
        check("simul_lost", 32'(lost_cnt), 32'd2);
        step();
        check("simul_after", 32'(seq_state), 32'd0);

        // Repeated losses from HOLD: lost_cnt saturates at 255.
        exp_lost = 2;
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b1;
            repeat (6) step();
            check("sat_hold", 32'(seq_state), 32'd1);
            pll_lock = 1'b0;
            repeat (3) step();
            exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
            check("sat_lost", 32'(lost_cnt), 32'(exp_lost));
        end
        check("sat_final", 32'(lost_cnt), 32'd255);

        // Asynchronous reset mid-SETTLE drops everything without a clock edge.
        pll_lock = 1'b1;
        repeat (25) step();
        check("pre_reset_settle", 32'({seq_state, div_resetn, div_ready}), 32'({2'd2, 1'b1, 1'b0}));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 32'({seq_state, div_resetn, div_ready, lost_cnt}), 32'd0);
        @(negedge hclkin);
        check("reset_hold", 32'({seq_state, div_resetn, div_ready, lost_cnt}), 32'd0);
        reset = 1'b0;
        step();
        check("post_reset", 32'({seq_state, div_resetn, div_ready, lost_cnt}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
